// File: rtl/wasm_leb128_pkg.sv
// Shared LEB128 decode definitions: modes, error codes, byte limits, FSM states.
package wasm_leb128_pkg;

  localparam logic [1:0] ModeVarint32  = 2'b00;
  localparam logic [1:0] ModeVarint64  = 2'b01;
  localparam logic [1:0] ModeVaruint32 = 2'b10;
  localparam logic [1:0] ModeVaruint1  = 2'b11;

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrOverlong = 2'd1;
  localparam logic [1:0] ErrPadding  = 2'd2;
  localparam logic [1:0] ErrMode     = 2'd3;

  // Payload bits beyond 63 can never reach a 64-bit result, so 64 is enough.
  localparam int unsigned AccW = 64;

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  // Largest legal encoding length for each mode.
  function automatic logic [3:0] max_bytes(input logic [1:0] mode);
    logic [3:0] n;
    unique case (mode)
      ModeVarint32:  n = 4'd5;
      ModeVarint64:  n = 4'd10;
      ModeVaruint32: n = 4'd5;
      ModeVaruint1:  n = 4'd1;
      default:       n = 4'd5;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/leb128_final_check.sv
// Validates the last permitted byte of an encoding: continuation and unused high bits.
module leb128_final_check
  import wasm_leb128_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [7:0] byte_i,
  output logic [1:0] err_o
);

  // Overlong wins over padding; padding bits must match the value's extension.
  always_comb begin
    err_o = ErrNone;
    if (byte_i[7]) begin
      err_o = ErrOverlong;
    end else begin
      unique case (mode_i)
        ModeVarint32:  if (byte_i[6:4] != {3{byte_i[3]}}) err_o = ErrPadding;
        ModeVaruint32: if (byte_i[6:4] != 3'd0) err_o = ErrPadding;
        ModeVarint64:  if (byte_i[6:1] != {6{byte_i[0]}}) err_o = ErrPadding;
        ModeVaruint1:  if (byte_i[6:1] != 6'd0) err_o = ErrPadding;
        default:       err_o = ErrNone;
      endcase
    end
  end

endmodule

// File: rtl/leb128_stream_decoder.sv
// Byte-serial LEB128 decoder with valid/ready input and held result output.
module leb128_stream_decoder
  import wasm_leb128_pkg::*;
#(
  parameter int unsigned OUT_W = 64,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic [LEN_W-1:0] out_len,
  output logic [1:0]       out_error,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [3:0]         idx_q, idx_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         err_q, err_d;

  logic [AccW-1:0]    acc_next;
  logic               is_last;
  logic [1:0]         chk_err;
  logic [63:0]        ext_value;
  logic [63:0]        ext_raw;
  int unsigned        fill_pos;
  int unsigned        sign_bits;

  leb128_final_check u_final_check (
    .mode_i (mode_q),
    .byte_i (in_byte),
    .err_o  (chk_err)
  );

  // Accumulator with the incoming payload merged at bit 7*index.
  always_comb begin
    acc_next = acc_q | (AccW'(in_byte[6:0]) << (7 * 32'(idx_q)));
    is_last  = (idx_q == (max_bytes(mode_q) - 4'd1));
  end

  // Sign-fill above the received bits, then widen from the mode's native width.
  always_comb begin
    fill_pos  = 7 * (32'(idx_q) + 32'd1);
    sign_bits = (mode_q == ModeVarint64) ? 32'd64 : 32'd32;
    ext_raw   = acc_next;
    ext_value = 64'd0;
    if (!mode_q[1]) begin
      if (in_byte[6] && (fill_pos < sign_bits)) begin
        ext_raw = ext_raw | (~64'd0 << fill_pos);
      end
      ext_value = (mode_q == ModeVarint32) ? {{32{ext_raw[31]}}, ext_raw[31:0]} : ext_raw;
    end else if (mode_q == ModeVaruint1) begin
      ext_value = {63'd0, ext_raw[0]};
    end else begin
      ext_value = {32'd0, ext_raw[31:0]};
    end
  end

  // Next-state and result capture.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    value_d = value_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d = mode;
          acc_d  = '0;
          idx_d  = 4'd0;
          if ((mode == ModeVarint64) && (OUT_W == 32)) begin
            state_d = StDone;
            err_d   = ErrMode;
            len_d   = '0;
            value_d = '0;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (in_valid) begin
          acc_d = acc_next;
          idx_d = idx_q + 4'd1;
          if (!in_byte[7] || is_last) begin
            state_d = StDone;
            len_d   = LEN_W'(idx_q + 4'd1);
            if (is_last && (chk_err != ErrNone)) begin
              err_d   = chk_err;
              value_d = '0;
            end else begin
              err_d   = ErrNone;
              value_d = ext_value[OUT_W-1:0];
            end
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      acc_q   <= '0;
      idx_q   <= 4'd0;
      value_q <= '0;
      len_q   <= '0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StCollect);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_value = value_q;
  assign out_len   = len_q;
  assign out_error = err_q;

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Bench for leb128_stream_decoder: directed vectors plus random streams vs a reference model.
module tb_leb128_stream_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic [1:0]  out_error;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  bit gaps = 1'b0;
  logic [7:0] stim_q[$];

  leb128_stream_decoder #(.OUT_W(64), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_len   (out_len),
    .out_error (out_error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: arbitrary-precision style decode with range checks on the final value.
  function automatic void ref_decode(input logic [1:0] m, output logic [63:0] v,
                                     output int len, output logic [1:0] err);
    int maxb, n;
    bit sgn;
    logic signed [127:0] acc, lim;
    logic [7:0] b;
    maxb = (m == 2'b01) ? 10 : (m == 2'b11) ? 1 : 5;
    n    = (m == 2'b01) ? 64 : (m == 2'b11) ? 1 : 32;
    sgn  = (m == 2'b00) || (m == 2'b01);
    acc = 0; len = 0; err = 0; v = 0; b = 0;
    for (int k = 0; k < stim_q.size(); k++) begin
      b   = stim_q[k];
      acc = acc + (128'(b[6:0]) << (7 * k));
      len = k + 1;
      if (!b[7] || len == maxb) break;
    end
    if (sgn && b[6]) acc = acc - (128'sd1 <<< (7 * len));
    lim = 128'sd1 <<< (sgn ? n - 1 : n);
    if (len == maxb && b[7]) err = 2'd1;
    else if (sgn ? (acc < -lim || acc >= lim) : (acc >= lim)) err = 2'd2;
    if (err != 0) v = 64'd0;
    else if (n == 32) v = sgn ? {{32{acc[31]}}, acc[31:0]} : {32'd0, acc[31:0]};
    else v = acc[63:0];
  endfunction

  // Run one decode over stim_q and check result, length, latency, hold and retire.
  task automatic run_decode(input logic [1:0] m, input logic [63:0] exp_v, input int exp_len,
                            input logic [1:0] exp_err, input int hold, input string tag);
    int k, det, last_iter;
    bit done;
    k = 0; det = -1; last_iter = -10; done = 1'b0;
    @(negedge clk);
    mode = m; start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        done = 1'b1;
        det  = cyc;
      end else begin
        in_valid = 1'b0;
        if (in_ready && k < stim_q.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
          in_valid = 1'b1;
          in_byte  = stim_q[k];
          k++;
          last_iter = cyc;
        end
        // A start mid-decode must be ignored, including its mode.
        if (in_ready && $urandom_range(0, 7) == 0) begin
          start = 1'b1;
          mode  = 2'($urandom);
        end
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: out_valid not seen, accepted %0d bytes, required %0d",
               tag, k, exp_len);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    // Junk offered during DONE must not be consumed.
    in_valid = 1'b1;
    in_byte  = 8'($urandom);
    n_vec++;
    if (out_value !== exp_v) begin
      n_err++;
      $display("FAIL %s value: got %h required %h", tag, out_value, exp_v);
    end
    n_vec++;
    if (out_len !== 4'(exp_len) || k != exp_len) begin
      n_err++;
      $display("FAIL %s len: out_len %0d accepted %0d required %0d", tag, out_len, k, exp_len);
    end
    n_vec++;
    if (out_error !== exp_err) begin
      n_err++;
      $display("FAIL %s error: got %0d required %0d", tag, out_error, exp_err);
    end
    n_vec++;
    if (det != last_iter + 1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s timing: done at %0d last byte at %0d in_ready %b busy %b", tag, det,
               last_iter, in_ready, busy);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_byte = 8'($urandom);
      n_vec++;
      if (out_valid !== 1'b1 || out_value !== exp_v || out_len !== 4'(exp_len) ||
          out_error !== exp_err || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold%0d: valid %b value %h len %0d err %0d required 1 %h %0d %0d",
                 tag, h, out_valid, out_value, out_len, out_error, exp_v, exp_len, exp_err);
      end
    end
    out_ready = 1'b1;
    start     = 1'($urandom);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s retire: out_valid %b busy %b required 0 0", tag, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_value !== 64'd0 ||
        out_len !== 4'd0 || out_error !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: valid %b ready %b busy %b value %h len %0d err %0d required 0",
               out_valid, in_ready, busy, out_value, out_len, out_error);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    gaps = 1'b0;
    stim_q = '{8'hE5, 8'h8E, 8'h26};
    run_decode(2'b00, 64'd624485, 3, 2'd0, 0, "v32_e58e26");
    stim_q = '{8'h7F};
    run_decode(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'd0, 0, "v32_7f");
    stim_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
    run_decode(2'b01, 64'h8000_0000_0000_0000, 10, 2'd0, 0, "v64_min");
    stim_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_decode(2'b00, 64'd0, 5, 2'd1, 0, "v32_overlong");
    stim_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h4F};
    run_decode(2'b00, 64'd0, 5, 2'd2, 0, "v32_badpad");
    stim_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    run_decode(2'b10, 64'h0000_0000_FFFF_FFFF, 5, 2'd0, 3, "vu32_max_hold3");
    stim_q = '{8'h03};
    run_decode(2'b11, 64'd0, 1, 2'd2, 0, "vu1_badpad");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_byte = 8'h80;
    @(negedge clk);
    in_byte = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: valid %b busy %b ready %b required 0 0 0", out_valid, busy,
               in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    stim_q = '{8'h01};
    run_decode(2'b11, 64'd1, 1, 2'd0, 0, "vu1_after_reset");
  endtask

  task automatic test_random(input int count);
    logic [1:0]  m;
    logic [63:0] ev;
    logic [1:0]  ee;
    logic [7:0]  b;
    int el, maxb, len;
    gaps = 1'b1;
    for (int t = 0; t < count; t++) begin
      m    = 2'($urandom_range(0, 3));
      maxb = (m == 2'b01) ? 10 : (m == 2'b11) ? 1 : 5;
      len  = $urandom_range(1, maxb + 1);
      stim_q.delete();
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        b[7] = (i < len - 1) || (len > maxb);
        // Half of the full-length encodings get legal padding so both outcomes occur.
        if (i == maxb - 1 && !b[7] && $urandom_range(0, 1) == 1) begin
          unique case (m)
            2'b00: b[6:4] = {3{b[3]}};
            2'b10: b[6:4] = 3'd0;
            2'b01: b[6:1] = {6{b[0]}};
            default: b[6:1] = 6'd0;
          endcase
        end
        stim_q.push_back(b);
      end
      stim_q.push_back(8'($urandom));
      ref_decode(m, ev, el, ee);
      run_decode(m, ev, el, ee, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
